multi_phase_traffic_controller: RTL

Parametrised traffic and pedestrian light controller for NUM_PHASES signal approaches, each with vehicle red/amber/green and a walk signal, cycled round-robin with all-red clearance between phases. It generalises the fixed four-way controller: configurable phase count and durations, per-phase latched walk requests with flashing clearance, and an optional protected left-turn arrow. It sits under the board-level test wrapper, which maps its outputs onto HEX/LED segments.

---
 rtl/multi_phase_traffic_controller.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_phase_traffic_controller.sv
// Round-robin traffic/pedestrian controller for NUM_PHASES approaches with all-red clearance,
// latched walk requests and flashing walk clearance. Define LEFT_TURN_EN to build the phase-0 arrow.
module mptc_lane (
  input  logic clk,
  input  logic reset,
  input  logic sel_cur,
  input  logic sel_nxt,
  input  logic n_green,
  input  logic n_amber,
  input  logic n_walk,
  input  logic req,
  input  logic clr,
  output logic red,
  output logic amber,
  output logic green,
  output logic walk,
  output logic pending
);
  always_ff @(posedge clk) begin
    if (reset) begin
      red     <= 1'b1;
      amber   <= 1'b0;
      green   <= 1'b0;
      walk    <= 1'b0;
      pending <= 1'b0;
    end else begin
      green <= sel_nxt & n_green;
      amber <= sel_nxt & n_amber;
      red   <= ~(sel_nxt & (n_green | n_amber));
      walk  <= sel_nxt & n_walk;
      // a new request beats the GREEN-entry clear so it is served next lap
      if (req)                pending <= 1'b1;
      else if (clr & sel_cur) pending <= 1'b0;
    end
  end
endmodule

module multi_phase_traffic_controller #(
  parameter int NUM_PHASES   = 4,
  parameter int TICK_DIV     = 27000000,
  parameter int GREEN_TICKS  = 10,
  parameter int AMBER_TICKS  = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int FLASH_TICKS  = 4,
  parameter int ARROW_TICKS  = 5,
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  debug,
  input  logic [NUM_PHASES-1:0] walk_req,
  input  logic                  left_turn_req,
  output logic [NUM_PHASES-1:0] phase_red,
  output logic [NUM_PHASES-1:0] phase_amber,
  output logic [NUM_PHASES-1:0] phase_green,
  output logic [NUM_PHASES-1:0] walk,
  output logic                  left_arrow,
  output logic [PW-1:0]         cur_phase,
  output logic [NUM_PHASES-1:0] walk_pending
);
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXD = max2(max2(max2(GREEN_TICKS, AMBER_TICKS), max2(ALLRED_TICKS, FLASH_TICKS)),
                             ARROW_TICKS);
  localparam int TW   = $clog2(MAXD) + 1;
  localparam int DW   = $clog2(TICK_DIV) + 1;

  typedef enum logic [2:0] {
    S_ALL_RED = 3'd0,
`ifdef LEFT_TURN_EN
    S_ARROW   = 3'd1,
`endif
    S_GREEN   = 3'd2,
    S_FLASH   = 3'd3,
    S_AMBER   = 3'd4
  } state_t;

  state_t          state, nstate;
  logic [TW-1:0]   timer, ntimer;
  logic [PW-1:0]   nphase;
  logic            served, nserved;
  logic            flash_walk, nflash;
  logic            go_green;
  logic [DW-1:0]   div;
  logic            debug_q;
  logic            tick;

  assign tick = debug | (div == DW'(TICK_DIV - 1));

`ifdef LEFT_TURN_EN
  logic arrow_latch, arrow_entry;
`else
  logic unused_left_turn_req;
  assign unused_left_turn_req = left_turn_req;
  assign left_arrow = 1'b0;
`endif

  always_comb begin
    nstate   = state;
    ntimer   = timer;
    nphase   = cur_phase;
    nserved  = served;
    nflash   = flash_walk;
    go_green = 1'b0;
`ifdef LEFT_TURN_EN
    arrow_entry = 1'b0;
`endif
    if (tick) begin
      if (timer == '0) begin
        unique case (state)
          S_ALL_RED: begin
`ifdef LEFT_TURN_EN
            if (cur_phase == '0 && arrow_latch) begin
              nstate      = S_ARROW;
              ntimer      = TW'(ARROW_TICKS - 1);
              arrow_entry = 1'b1;
            end else
`endif
              go_green = 1'b1;
          end
`ifdef LEFT_TURN_EN
          S_ARROW: go_green = 1'b1;
`endif
          S_GREEN: begin
            if (served) begin
              nstate = S_FLASH;
              ntimer = TW'(FLASH_TICKS - 1);
              nflash = 1'b0;
            end else begin
              nstate = S_AMBER;
              ntimer = TW'(AMBER_TICKS - 1);
            end
          end
          S_FLASH: begin
            nstate = S_AMBER;
            ntimer = TW'(AMBER_TICKS - 1);
            nflash = 1'b0;
          end
          S_AMBER: begin
            nstate = S_ALL_RED;
            ntimer = TW'(ALLRED_TICKS - 1);
            nphase = (cur_phase == PW'(NUM_PHASES - 1)) ? '0 : cur_phase + 1'b1;
          end
          default: begin
            nstate = S_ALL_RED;
            ntimer = TW'(ALLRED_TICKS - 1);
          end
        endcase
      end else begin
        ntimer = timer - 1'b1;
        if (state == S_FLASH) nflash = ~flash_walk;
      end
    end
    if (go_green) begin
      nstate  = S_GREEN;
      ntimer  = TW'(GREEN_TICKS - 1);
      nserved = walk_pending[cur_phase];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_ALL_RED;
      timer      <= TW'(ALLRED_TICKS - 1);
      cur_phase  <= '0;
      served     <= 1'b0;
      flash_walk <= 1'b0;
      div        <= '0;
      debug_q    <= debug;
`ifdef LEFT_TURN_EN
      arrow_latch <= 1'b0;
      left_arrow  <= 1'b0;
`endif
    end else begin
      state      <= nstate;
      timer      <= ntimer;
      cur_phase  <= nphase;
      served     <= nserved;
      flash_walk <= nflash;
      debug_q    <= debug;
      // realign the divider whenever the speed mode flips
      if (debug != debug_q || div == DW'(TICK_DIV - 1)) div <= '0;
      else                                              div <= div + 1'b1;
`ifdef LEFT_TURN_EN
      if (left_turn_req)    arrow_latch <= 1'b1;
      else if (arrow_entry) arrow_latch <= 1'b0;
      left_arrow <= (nstate == S_ARROW);
`endif
    end
  end

  logic n_green, n_amber, n_walk;
  assign n_green = (nstate == S_GREEN) || (nstate == S_FLASH);
  assign n_amber = (nstate == S_AMBER);
  assign n_walk  = ((nstate == S_GREEN) && nserved) || ((nstate == S_FLASH) && nflash);

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_lane
    mptc_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .sel_cur (cur_phase == PW'(i)),
      .sel_nxt (nphase == PW'(i)),
      .n_green (n_green),
      .n_amber (n_amber),
      .n_walk  (n_walk),
      .req     (walk_req[i]),
      .clr     (go_green),
      .red     (phase_red[i]),
      .amber   (phase_amber[i]),
      .green   (phase_green[i]),
      .walk    (walk[i]),
      .pending (walk_pending[i])
    );
  end
endmodule
